// File: rtl/volume_pkg.sv
// Shared constants and types for the volume meter: level encoding and FSM states.
package volume_pkg;
    localparam int LEVEL_W    = 8;
    localparam int LEVEL_MAX  = 100;
    localparam int LEVEL_STEP = 10;
    localparam int NUM_STEPS  = LEVEL_MAX / LEVEL_STEP;

    typedef enum logic {
        S_IDLE,
        S_ACC
    } state_t;

    function automatic logic [LEVEL_W-1:0] level_max(
        input logic [LEVEL_W-1:0] a,
        input logic [LEVEL_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/volume_meter_if.sv
// Sample input bus and per-window meter results of the volume meter.
interface volume_meter_if
    import volume_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int CH     = 2
);
    logic                    in_valid;
    logic [CH*DATA_W-1:0]    in_data;
    logic                    o_valid;
    logic [CH*LEVEL_W-1:0]   o_avg;
    logic [CH*LEVEL_W-1:0]   o_peak;

    modport master (
        output in_valid, in_data,
        input  o_valid, o_avg, o_peak
    );

    modport slave (
        input  in_valid, in_data,
        output o_valid, o_avg, o_peak
    );
endinterface

// File: rtl/volume_level.sv
// Combinational sample-to-level map: saturating magnitude, then log2 bucket in steps of 10.
module volume_level
    import volume_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0]  i_sample,
    output logic [LEVEL_W-1:0] o_level
);
    logic [DATA_W-2:0] w_mag;

    // The most negative code has no positive twin, so it clamps to full scale.
    always_comb begin
        if (!i_sample[DATA_W-1]) begin
            w_mag = i_sample[DATA_W-2:0];
        end else if (i_sample[DATA_W-2:0] == '0) begin
            w_mag = '1;
        end else begin
            w_mag = (~i_sample[DATA_W-2:0]) + 1'b1;
        end
    end

    always_comb begin
        o_level = '0;
        for (int i = 0; i < NUM_STEPS; i++) begin
            if (w_mag >= (DATA_W-1)'(1) << (DATA_W - 1 - NUM_STEPS + i)) begin
                o_level = LEVEL_W'(LEVEL_STEP * (i + 1));
            end
        end
    end
endmodule

// File: rtl/volume_meter.sv
// Multi-channel volume meter: windowed average and peak level per channel.
// Optional peak-hold with decay is enabled by defining VOLUME_METER_PEAK_HOLD_EN.
module volume_meter
    import volume_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int LOG2_NUM   = 11,
    parameter int CH         = 2,
    parameter int DECAY_STEP = 10
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_en,
    volume_meter_if.slave  bus
);
    localparam int ACC_W = 7 + LOG2_NUM;

    state_t              r_state;
    logic [LOG2_NUM-1:0] r_cnt;
    logic                r_valid;
    logic                w_accept;
    logic                w_last;

    assign w_accept = i_en && bus.in_valid;
    assign w_last   = w_accept && (r_cnt == '1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (!i_en) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
            end else if (bus.in_valid) begin
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_ACC;
                        r_cnt   <= r_cnt + 1'b1;
                    end
                    S_ACC: begin
                        if (w_last) begin
                            r_state <= S_IDLE;
                            r_cnt   <= '0;
                            r_valid <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.o_valid = r_valid;

    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
        logic [LEVEL_W-1:0] w_level;
        logic [LEVEL_W-1:0] w_wmax;
        logic [LEVEL_W-1:0] w_hold_next;
        logic [ACC_W-1:0]   w_sum;
        logic [ACC_W-1:0]   r_acc;
        logic [LEVEL_W-1:0] r_wpeak;
        logic [LEVEL_W-1:0] r_avg;
        logic [LEVEL_W-1:0] r_peak;

        volume_level #(
            .DATA_W (DATA_W)
        ) u_level (
            .i_sample (bus.in_data[gi*DATA_W +: DATA_W]),
            .o_level  (w_level)
        );

        // Sums include the current sample so the window-closing sample counts.
        assign w_sum  = r_acc + ACC_W'(w_level);
        assign w_wmax = level_max(w_level, r_wpeak);

`ifdef VOLUME_METER_PEAK_HOLD_EN
        logic [LEVEL_W-1:0] w_decay;
        assign w_decay = (r_peak > LEVEL_W'(DECAY_STEP)) ? r_peak - LEVEL_W'(DECAY_STEP) : '0;
        assign w_hold_next = (w_wmax >= r_peak) ? w_wmax : level_max(w_wmax, w_decay);
`else
        assign w_hold_next = w_wmax;
`endif

        // r_peak is the hold register when peak-hold is built in; i_en never clears it.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_acc   <= '0;
                r_wpeak <= '0;
                r_avg   <= '0;
                r_peak  <= '0;
            end else if (!i_en) begin
                r_acc   <= '0;
                r_wpeak <= '0;
            end else if (bus.in_valid) begin
                if (w_last) begin
                    r_acc   <= '0;
                    r_wpeak <= '0;
                    r_avg   <= {1'b0, w_sum[ACC_W-1:LOG2_NUM]};
                    r_peak  <= w_hold_next;
                end else begin
                    r_acc   <= w_sum;
                    r_wpeak <= w_wmax;
                end
            end
        end

        assign bus.o_avg[gi*LEVEL_W +: LEVEL_W]  = r_avg;
        assign bus.o_peak[gi*LEVEL_W +: LEVEL_W] = r_peak;
    end
endmodule

// File: tb/tb_volume_meter.sv
// Directed bench for volume_meter: a reference model pushes expected window results to a
// scoreboard while samples are driven; a monitor pops and compares on every o_valid pulse.
module tb_volume_meter;
    import volume_pkg::*;

    localparam int DW  = 16;
    localparam int LN  = 4;
    localparam int NCH = 2;
    localparam int NUM = 1 << LN;
`ifdef VOLUME_METER_PEAK_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic en;

    always #5 clk = ~clk;

    volume_meter_if #(.DATA_W(DW), .CH(NCH)) bus ();

    volume_meter #(
        .DATA_W     (DW),
        .LOG2_NUM   (LN),
        .CH         (NCH),
        .DECAY_STEP (10)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .i_en  (en),
        .bus   (bus)
    );

    typedef struct {
        int cyc;
        int avg0;
        int avg1;
        int pk0;
        int pk1;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    int m_acc[NCH];
    int m_pk[NCH];
    int m_hold[NCH];
    int m_avg[NCH];
    int m_peak[NCH];
    int m_cnt;

    always @(posedge clk) cyc <= cyc + 1;

    // Threshold form of the level map: magnitude >= 2^(4+k) gives level 10*k.
    function automatic int lvl(input logic [15:0] x);
        int v;
        int r;
        v = int'($signed(x));
        if (v < 0) v = -v;
        if (v > 32767) v = 32767;
        r = 0;
        for (int k = 1; k <= 10; k++) begin
            if (v >= (1 << (4 + k))) r = 10 * k;
        end
        return r;
    endfunction

    task automatic check(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_clear_window();
        for (int c = 0; c < NCH; c++) begin
            m_acc[c] = 0;
            m_pk[c]  = 0;
        end
        m_cnt = 0;
    endtask

    task automatic model_window_end();
        exp_t e;
        int   d;
        for (int c = 0; c < NCH; c++) begin
            m_avg[c] = m_acc[c] / NUM;
            if (HOLD) begin
                if (m_pk[c] >= m_hold[c]) begin
                    m_hold[c] = m_pk[c];
                end else begin
                    d = m_hold[c] - 10;
                    if (d < 0) d = 0;
                    m_hold[c] = (m_pk[c] > d) ? m_pk[c] : d;
                end
                m_peak[c] = m_hold[c];
            end else begin
                m_peak[c] = m_pk[c];
            end
        end
        e.cyc  = cyc + 1;
        e.avg0 = m_avg[0];
        e.avg1 = m_avg[1];
        e.pk0  = m_peak[0];
        e.pk1  = m_peak[1];
        sb.push_back(e);
        model_clear_window();
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b);
        int l;
        bus.in_valid = 1'b1;
        bus.in_data  = {b, a};
        if (en) begin
            for (int c = 0; c < NCH; c++) begin
                l = lvl((c == 0) ? a : b);
                m_acc[c] += l;
                if (l > m_pk[c]) m_pk[c] = l;
            end
            m_cnt++;
            if (m_cnt == NUM) model_window_end();
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_clear_window();
        for (int c = 0; c < NCH; c++) begin
            m_hold[c] = 0;
            m_avg[c]  = 0;
            m_peak[c] = 0;
        end
    endtask

    // i_en low with in_valid high: the sample must be ignored and the window restart.
    task automatic en_low();
        en           = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = {16'h4000, 16'h4000};
        @(negedge clk);
        en           = 1'b1;
        bus.in_valid = 1'b0;
        model_clear_window();
    endtask

    task automatic check_outs(input string tag);
        check({tag, "_avg0"},  int'(bus.o_avg[7:0]),   m_avg[0]);
        check({tag, "_avg1"},  int'(bus.o_avg[15:8]),  m_avg[1]);
        check({tag, "_peak0"}, int'(bus.o_peak[7:0]),  m_peak[0]);
        check({tag, "_peak1"}, int'(bus.o_peak[15:8]), m_peak[1]);
    endtask

    always @(negedge clk) begin
        if (bus.o_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_o_valid", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("win_valid_cycle", cyc, mon_e.cyc);
                check("win_avg0",  int'(bus.o_avg[7:0]),   mon_e.avg0);
                check("win_avg1",  int'(bus.o_avg[15:8]),  mon_e.avg1);
                check("win_peak0", int'(bus.o_peak[7:0]),  mon_e.pk0);
                check("win_peak1", int'(bus.o_peak[15:8]), mon_e.pk1);
                $display("window end cycle=%0d avg=%0d/%0d peak=%0d/%0d",
                         cyc, mon_e.avg0, mon_e.avg1, mon_e.pk0, mon_e.pk1);
            end
        end
    end

    initial begin
        rst          = 1'b1;
        en           = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        for (int c = 0; c < NCH; c++) begin
            m_hold[c] = 0;
            m_avg[c]  = 0;
            m_peak[c] = 0;
        end
        model_clear_window();
        repeat (3) @(negedge clk);
        check("rst_o_valid", int'(bus.o_valid), 0);
        check("rst_o_avg",   int'(bus.o_avg),   0);
        check("rst_o_peak",  int'(bus.o_peak),  0);
        rst = 1'b0;
        idle(2);

        // Full scale against silence
        repeat (NUM) send(16'h4000, 16'h0000);
        idle(3);
        check_outs("t1_hold");
        check("t1_avg0_100", int'(bus.o_avg[7:0]), 100);
        check("t1_avg1_0",   int'(bus.o_avg[15:8]), 0);
        check("t1_peak0_100", int'(bus.o_peak[7:0]), 100);

        // Most negative code saturates; -32 sits on the lowest non-zero step
        repeat (NUM) send(16'h8000, 16'hFFE0);
        idle(2);
        check("t2_avg0_100", int'(bus.o_avg[7:0]), 100);
        check("t2_avg1_10",  int'(bus.o_avg[15:8]), 10);

        // Gapped input, mixed levels
        for (int i = 0; i < NUM; i++) begin
            send((i < 8) ? 16'h0400 : 16'h0000, 16'h0000);
            idle(1);
        end
        idle(2);
        check("t3_avg0_30",  int'(bus.o_avg[7:0]), 30);
        check("t3_peak0_60", int'(bus.o_peak[7:0]), HOLD ? 90 : 60);
        check_outs("t3");

        // Back-to-back windows with different content
        repeat (NUM) send(16'h4000, 16'h4000);
        repeat (NUM) send(16'h0100, 16'h0020);
        idle(2);
        check("t4_avg0_40", int'(bus.o_avg[7:0]), 40);
        check("t4_avg1_10", int'(bus.o_avg[15:8]), 10);

        // Reset mid-window
        repeat (10) send(16'h4000, 16'h4000);
        do_reset();
        check("t5_rst_valid", int'(bus.o_valid), 0);
        check("t5_rst_avg",   int'(bus.o_avg),   0);
        check("t5_rst_peak",  int'(bus.o_peak),  0);
        repeat (NUM) send(16'h0100, 16'h0100);
        idle(2);
        check("t5_avg0_40", int'(bus.o_avg[7:0]), 40);
        check_outs("t5");

        // Enable low mid-window: outputs hold, window restarts
        repeat (NUM) send(16'h4000, 16'h0000);
        idle(1);
        repeat (10) send(16'h0100, 16'h0100);
        en_low();
        check("t6_en_valid", int'(bus.o_valid), 0);
        check_outs("t6_en_hold");
        check("t6_en_avg0_100", int'(bus.o_avg[7:0]), 100);
        repeat (NUM) send(16'h0400, 16'h0400);
        idle(2);
        check("t6_avg0_60", int'(bus.o_avg[7:0]), 60);

        // Peak hold: one loud window followed by three silent windows
        repeat (NUM) send(16'h4000, 16'h4000);
        repeat (3 * NUM) send(16'h0000, 16'h0000);
        idle(3);
        check("t7_final_peak0", int'(bus.o_peak[7:0]), HOLD ? 70 : 0);
        check_outs("t7");

        idle(3);
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
